// File: rtl/axi_wrr_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : axi_wrr_arbiter
// Brief   : Weighted round-robin arbiter with optional exclusive lock and an
//           optional registered output stage.
// Revision: 1.0 - initial release
// ============================================================================
module axi_wrr_arbiter #(
    parameter int N_MASTER     = 5,
    parameter int AUX_WIDTH    = 64,
    parameter int ID_WIDTH     = 20,
    parameter int WEIGHT_WIDTH = 4,
    parameter int OUT_REG      = 1,
    localparam int LOG_MASTER  = $clog2(N_MASTER)
) (
    input  logic                                      clk,
    input  logic                                      rst,
    input  logic [N_MASTER-1:0]                       data_req_i,
    input  logic [N_MASTER-1:0][AUX_WIDTH-1:0]        data_AUX_i,
    input  logic [N_MASTER-1:0][ID_WIDTH-1:0]         data_ID_i,
    output logic [N_MASTER-1:0]                       data_gnt_o,
    input  logic [N_MASTER-1:0][WEIGHT_WIDTH-1:0]     weight_i,
    input  logic                                      lock,
    input  logic [LOG_MASTER-1:0]                     SEL_EXCLUSIVE,
    output logic                                      data_req_o,
    output logic [AUX_WIDTH-1:0]                      data_AUX_o,
    output logic [ID_WIDTH-1:0]                       data_ID_o,
    output logic [LOG_MASTER-1:0]                     data_sel_o,
    input  logic                                      data_gnt_i
);

    localparam logic [LOG_MASTER:0] c_n_master = N_MASTER[LOG_MASTER:0];

    logic [LOG_MASTER-1:0]   r_ptr;
    logic [WEIGHT_WIDTH-1:0] r_cnt;

    logic [N_MASTER-1:0]     w_elig;
    logic [LOG_MASTER-1:0]   w_sel;
    logic [LOG_MASTER-1:0]   w_ptr_nxt;
    logic [AUX_WIDTH-1:0]    w_aux;
    logic [ID_WIDTH-1:0]     w_id;
    logic [WEIGHT_WIDTH-1:0] w_weight;
    logic [WEIGHT_WIDTH-1:0] w_w;
    logic [WEIGHT_WIDTH:0]   w_cnt_inc;
    logic                    w_any;
    logic                    w_up_rdy;
    logic                    w_xfer;

    // A SEL_EXCLUSIVE beyond the last master matches no index, so the set empties.
    always_comb begin
        w_elig = '0;
        for (int k = 0; k < N_MASTER; k++) begin
            w_elig[k] = data_req_i[k] && (!lock || (int'(SEL_EXCLUSIVE) == k));
        end
    end

    // Circular scan upward from r_ptr; the first eligible index wins.
    always_comb begin
        logic [LOG_MASTER:0]   v_sum;
        logic [LOG_MASTER-1:0] v_idx;
        logic                  v_found;
        v_found  = 1'b0;
        v_sum    = '0;
        v_idx    = '0;
        w_sel    = '0;
        w_aux    = data_AUX_i[0];
        w_id     = data_ID_i[0];
        w_weight = weight_i[0];
        for (int k = 0; k < N_MASTER; k++) begin
            v_sum = {1'b0, r_ptr} + (LOG_MASTER+1)'(k);
            if (v_sum >= c_n_master) begin
                v_sum = v_sum - c_n_master;
            end
            v_idx = v_sum[LOG_MASTER-1:0];
            if (!v_found && w_elig[v_idx]) begin
                v_found  = 1'b1;
                w_sel    = v_idx;
                w_aux    = data_AUX_i[v_idx];
                w_id     = data_ID_i[v_idx];
                w_weight = weight_i[v_idx];
            end
        end
    end

    assign w_any     = (|w_elig) && !rst;
    assign w_xfer    = w_any && w_up_rdy;
    assign w_w       = (w_weight == '0) ? WEIGHT_WIDTH'(1) : w_weight;
    assign w_cnt_inc = {1'b0, r_cnt} + (WEIGHT_WIDTH+1)'(1);
    assign w_ptr_nxt = ({1'b0, w_sel} == c_n_master - (LOG_MASTER+1)'(1)) ?
                       '0 : w_sel + LOG_MASTER'(1);

    always_comb begin
        data_gnt_o = '0;
        if (w_xfer) begin
            data_gnt_o[w_sel] = 1'b1;
        end
    end

    // Accounting runs regardless of lock so the rotation resumes where it left off.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ptr <= '0;
            r_cnt <= '0;
        end else if (w_xfer) begin
            if ((w_sel == r_ptr) && (w_cnt_inc < {1'b0, w_w})) begin
                r_cnt <= w_cnt_inc[WEIGHT_WIDTH-1:0];
            end else if ((w_sel != r_ptr) && (w_w > WEIGHT_WIDTH'(1))) begin
                r_ptr <= w_sel;
                r_cnt <= WEIGHT_WIDTH'(1);
            end else begin
                r_ptr <= w_ptr_nxt;
                r_cnt <= '0;
            end
        end
    end

    if (OUT_REG != 0) begin : g_out_reg
        logic                  r_valid;
        logic [AUX_WIDTH-1:0]  r_aux;
        logic [ID_WIDTH-1:0]   r_id;
        logic [LOG_MASTER-1:0] r_sel;

        assign w_up_rdy = !r_valid || data_gnt_i;

        // Capture takes priority over drain, giving back-to-back beats.
        always_ff @(posedge clk) begin
            if (rst) begin
                r_valid <= 1'b0;
                r_aux   <= '0;
                r_id    <= '0;
                r_sel   <= '0;
            end else if (w_xfer) begin
                r_valid <= 1'b1;
                r_aux   <= w_aux;
                r_id    <= w_id;
                r_sel   <= w_sel;
            end else if (data_gnt_i) begin
                r_valid <= 1'b0;
            end
        end

        assign data_req_o = r_valid && !rst;
        assign data_AUX_o = rst ? '0 : r_aux;
        assign data_ID_o  = rst ? '0 : r_id;
        assign data_sel_o = rst ? '0 : r_sel;
    end else begin : g_out_comb
        assign w_up_rdy   = data_gnt_i;
        assign data_req_o = w_any;
        assign data_AUX_o = rst ? '0 : w_aux;
        assign data_ID_o  = rst ? '0 : w_id;
        assign data_sel_o = rst ? '0 : w_sel;
    end

endmodule
`default_nettype wire

// File: tb/tb_axi_wrr_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : tb_axi_wrr_arbiter
// Brief   : Directed bench for axi_wrr_arbiter, registered and combinational.
// Revision: 1.0 - initial release
// ============================================================================
module tb_axi_wrr_arbiter;

    localparam int N = 5;

    logic                clk = 1'b0;
    logic                rst;
    logic [N-1:0]        req;
    logic [N-1:0][63:0]  aux;
    logic [N-1:0][19:0]  id;
    logic [N-1:0][3:0]   weight;
    logic                lock;
    logic [2:0]          sel_ex;
    logic                gnt_i;

    logic [N-1:0]        r_gnt,  c_gnt;
    logic                r_req,  c_req;
    logic [63:0]         r_aux,  c_aux;
    logic [19:0]         r_id,   c_id;
    logic [2:0]          r_sel,  c_sel;

    int n_cmp = 0;
    int n_err = 0;
    int exp_seq[7] = '{0, 1, 2, 3, 4, 4, 4};
    int wt_seq[6]  = '{1, 1, 3, 1, 1, 3};

    always #5 clk = ~clk;

    axi_wrr_arbiter #(.N_MASTER(N), .OUT_REG(1)) u_reg (
        .clk(clk), .rst(rst), .data_req_i(req), .data_AUX_i(aux), .data_ID_i(id),
        .data_gnt_o(r_gnt), .weight_i(weight), .lock(lock), .SEL_EXCLUSIVE(sel_ex),
        .data_req_o(r_req), .data_AUX_o(r_aux), .data_ID_o(r_id),
        .data_sel_o(r_sel), .data_gnt_i(gnt_i)
    );

    axi_wrr_arbiter #(.N_MASTER(N), .OUT_REG(0)) u_cmb (
        .clk(clk), .rst(rst), .data_req_i(req), .data_AUX_i(aux), .data_ID_i(id),
        .data_gnt_o(c_gnt), .weight_i(weight), .lock(lock), .SEL_EXCLUSIVE(sel_ex),
        .data_req_o(c_req), .data_AUX_o(c_aux), .data_ID_o(c_id),
        .data_sel_o(c_sel), .data_gnt_i(gnt_i)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Inputs change 1 time unit after the rising edge; checks 1 unit later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        #1;
    endtask

    initial begin
        rst    = 1'b1;
        req    = '1;
        lock   = 1'b0;
        sel_ex = '0;
        gnt_i  = 1'b1;
        weight = '0;
        for (int k = 0; k < N; k++) begin
            aux[k]    = 64'hA0 + 64'(k);
            id[k]     = 20'h100 + 20'(k);
            weight[k] = 4'd1;
        end
        tick();
        tick();
        #1;
        chk("rst_r_gnt", 64'(r_gnt), 64'h0);
        chk("rst_r_req", 64'(r_req), 64'h0);
        chk("rst_r_aux", r_aux, 64'h0);
        chk("rst_c_gnt", 64'(c_gnt), 64'h0);
        chk("rst_c_req", 64'(c_req), 64'h0);
        chk("rst_c_aux", c_aux, 64'h0);
        chk("rst_c_sel", 64'(c_sel), 64'h0);

        // Plain round robin, every master requesting.
        rst = 1'b0;
        #1;
        for (int i = 0; i < 7; i++) begin
            chk("rr_r_gnt", 64'(r_gnt), 64'(1) << (i % N));
            chk("rr_c_gnt", 64'(c_gnt), 64'(1) << (i % N));
            chk("rr_c_sel", 64'(c_sel), 64'(i % N));
            chk("rr_c_aux", c_aux, 64'hA0 + 64'(i % N));
            if (i == 0) begin
                chk("rr_r_req0", 64'(r_req), 64'h0);
            end else begin
                chk("rr_r_req", 64'(r_req), 64'h1);
                chk("rr_r_sel", 64'(r_sel), 64'((i - 1) % N));
                chk("rr_r_id", 64'(r_id), 64'h100 + 64'((i - 1) % N));
            end
            tick();
        end

        // Master 4 weighted 3.
        weight[4] = 4'd3;
        do_reset();
        for (int i = 0; i < 14; i++) begin
            chk("wt3_gnt", 64'(r_gnt), 64'(1) << exp_seq[i % 7]);
            tick();
        end

        // Weight 0 behaves as 1.
        weight = '0;
        do_reset();
        for (int i = 0; i < 6; i++) begin
            chk("wt0_gnt", 64'(c_gnt), 64'(1) << (i % N));
            tick();
        end

        // Masters 1 and 3 requesting, master 1 weighted 2.
        for (int k = 0; k < N; k++) weight[k] = 4'd1;
        weight[1] = 4'd2;
        req = 5'b01010;
        do_reset();
        for (int i = 0; i < 6; i++) begin
            chk("wt2_gnt", 64'(r_gnt), 64'(1) << wt_seq[i]);
            tick();
        end
        weight[1] = 4'd1;

        // Lone requester 3 from ptr 0, then ptr must sit at 4.
        req = 5'b01000;
        do_reset();
        chk("solo_gnt", 64'(r_gnt), 64'h08);
        tick();
        req = '1;
        #1;
        chk("solo_ptr4", 64'(r_gnt), 64'h10);
        chk("solo_sel", 64'(r_sel), 64'h3);
        chk("solo_aux", r_aux, 64'hA3);

        // Exclusive lock.
        do_reset();
        lock   = 1'b1;
        sel_ex = 3'd2;
        #1;
        for (int i = 0; i < 3; i++) begin
            chk("lock2_gnt", 64'(r_gnt), 64'h04);
            chk("lock2_cgnt", 64'(c_gnt), 64'h04);
            tick();
        end
        req = 5'b11011;
        #1;
        chk("lock2_noreq", 64'(c_gnt), 64'h0);
        chk("lock2_noreq_o", 64'(c_req), 64'h0);
        req    = '1;
        sel_ex = 3'd6;
        #1;
        chk("lock6_gnt", 64'(r_gnt), 64'h0);
        chk("lock6_creq", 64'(c_req), 64'h0);
        tick();
        chk("lock6_rreq", 64'(r_req), 64'h0);
        lock   = 1'b0;
        sel_ex = '0;

        // Downstream stall then full-rate drain.
        do_reset();
        gnt_i = 1'b0;
        #1;
        chk("stall_gnt0", 64'(r_gnt), 64'h01);
        chk("stall_cgnt", 64'(c_gnt), 64'h0);
        chk("stall_creq", 64'(c_req), 64'h1);
        tick();
        for (int i = 0; i < 3; i++) begin
            chk("stall_hold_gnt", 64'(r_gnt), 64'h0);
            chk("stall_hold_req", 64'(r_req), 64'h1);
            chk("stall_hold_sel", 64'(r_sel), 64'h0);
            chk("stall_hold_aux", r_aux, 64'hA0);
            tick();
        end
        gnt_i = 1'b1;
        #1;
        for (int i = 0; i < 4; i++) begin
            chk("drain_gnt", 64'(r_gnt), 64'(1) << (i + 1));
            chk("drain_req", 64'(r_req), 64'h1);
            chk("drain_sel", 64'(r_sel), 64'(i));
            tick();
        end

        // Reset with a beat pending.
        gnt_i = 1'b0;
        tick();
        chk("pend_req", 64'(r_req), 64'h1);
        rst = 1'b1;
        #1;
        chk("midrst_req", 64'(r_req), 64'h0);
        chk("midrst_gnt", 64'(r_gnt), 64'h0);
        tick();
        rst = 1'b0;
        #1;
        chk("postrst_req", 64'(r_req), 64'h0);
        chk("postrst_gnt", 64'(r_gnt), 64'h01);
        gnt_i = 1'b1;
        tick();
        chk("postrst_sel", 64'(r_sel), 64'h0);
        chk("postrst_aux", r_aux, 64'hA0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/axi_wrr_arbiter.md
AXI_WRR_ARBITER -- requirements
Module: axi_wrr_arbiter

Interface
REQ-001 Parameter N_MASTER, default 5: number of request ports; SHALL be 2..32 and need not be a power of 2.
REQ-002 Parameter AUX_WIDTH, default 64: width of the payload forwarded with each request.
REQ-003 Parameter ID_WIDTH, default 20: width of the ID forwarded with each request.
REQ-004 Parameter WEIGHT_WIDTH, default 4: width of each per-master weight.
REQ-005 Parameter OUT_REG, default 1: 1 = registered output stage, 0 = combinational output path.
REQ-006 Localparam LOG_MASTER = $clog2(N_MASTER).
REQ-007 clk  in  1  single clock, rising edge.
REQ-008 rst  in  1  reset, synchronous, active-high.
REQ-009 data_req_i  in  N_MASTER  per-master request.
REQ-010 data_AUX_i  in  N_MASTER x AUX_WIDTH  per-master payload.
REQ-011 data_ID_i  in  N_MASTER x ID_WIDTH  per-master ID.
REQ-012 data_gnt_o  out  N_MASTER  per-master grant; a transfer occurs when req and gnt are both high.
REQ-013 weight_i  in  N_MASTER x WEIGHT_WIDTH  consecutive-grant quota per master; value 0 is treated as 1.
REQ-014 lock  in  1  exclusive mode enable.
REQ-015 SEL_EXCLUSIVE  in  LOG_MASTER  index of the only master eligible while lock=1.
REQ-016 data_req_o  out  1  output request (valid).
REQ-017 data_AUX_o  out  AUX_WIDTH  forwarded payload.
REQ-018 data_ID_o  out  ID_WIDTH  forwarded ID.
REQ-019 data_sel_o  out  LOG_MASTER  index of the master whose data is on the output.
REQ-020 data_gnt_i  in  1  downstream ready.

Function
REQ-021 Eligible set: data_req_i masked to bit SEL_EXCLUSIVE when lock=1; empty when lock=1 and SEL_EXCLUSIVE >= N_MASTER.
REQ-022 Winner sel: the first eligible index found scanning circularly upward from pointer ptr (ptr, ptr+1, ..., N_MASTER-1, 0, ...); winner selection is combinational, with no bubble cycle.
REQ-023 Upstream ready: up_rdy = data_gnt_i when OUT_REG=0; up_rdy = (!out_valid || data_gnt_i) when OUT_REG=1.
REQ-024 data_gnt_o is one-hot or zero, = up_rdy at bit sel only when the eligible set is non-empty; masters outside the eligible set never see a grant.
REQ-025 OUT_REG=0: data_req_o = (eligible set non-empty); data_AUX_o, data_ID_o and data_sel_o follow sel combinationally.
REQ-026 OUT_REG=1: on an upstream transfer, AUX, ID and sel are captured and out_valid is set; out_valid clears on (out_valid && data_gnt_i) with no new capture.
REQ-027 OUT_REG=1: a simultaneous downstream drain and upstream capture keeps out_valid=1 and loads the new data, sustaining 1 transfer per cycle.
REQ-028 OUT_REG=1: the output registers hold stable while data_req_o=1 and data_gnt_i=0.
REQ-029 Weight accounting: ptr and cnt (WEIGHT_WIDTH bits) update only on an upstream transfer; W = max(weight_i[sel], 1).
REQ-030 If sel==ptr and cnt+1 < W: cnt <= cnt+1, ptr unchanged.
REQ-031 If sel!=ptr and W > 1: ptr <= sel, cnt <= 1.
REQ-032 Otherwise: ptr <= (sel+1) wrapped at N_MASTER (not at 2**LOG_MASTER), cnt <= 0.
REQ-033 Lock does not freeze accounting; ptr and cnt update per REQ-030..032 during lock.
REQ-034 A weight_i change takes effect on the next transfer; a cnt value already >= the new W-1 forces the pointer advance of REQ-032.

Reset
REQ-035 While rst=1 at a rising edge: ptr=0, cnt=0, out_valid=0.
REQ-036 While rst=1: data_req_o=0, data_gnt_o=0, data_AUX_o=0, data_ID_o=0, data_sel_o=0 for both OUT_REG values; the combinational path is gated by rst.
REQ-037 Reset asserted mid-burst discards any registered beat; the first grant after reset goes to the lowest-indexed requester.

Verification
REQ-038 N=5, all weights 1, all req=1, gnt_i=1 -> grants 0,1,2,3,4,0,... one per cycle; data_sel_o follows the same order (one cycle later if OUT_REG=1).
REQ-039 weight_i={1,1,1,1,3}, all req, gnt_i=1 -> repeating grant order 0,1,2,3,4,4,4.
REQ-040 Only master 3 requesting, ptr=0 -> master 3 granted in the same cycle; after one transfer ptr=4, cnt=0.
REQ-041 lock=1, SEL_EXCLUSIVE=2, all req -> only master 2 is granted; with SEL_EXCLUSIVE=6 (N=5) -> no grant and data_req_o=0.
REQ-042 OUT_REG=1, gnt_i held low 3 cycles -> one beat captured, data_gnt_o=0, outputs stable; gnt_i high -> a new beat loads every cycle with no bubble.
REQ-043 rst pulsed while out_valid=1 -> the next cycle shows data_req_o=0; the pending beat is never delivered.
